mac_bus_ctrl: RTL and testbench

Address decoder and bus-cycle terminator sitting directly downstream of the 68000-compatible CPU bus wrapper. Watches the CPU's strobes, address and function code, and raises the selected device's chip select. Terminates every bus cycle with exactly one of three responses:
- `dtack_n`, after per-region wait states or a device ready;
- `vpa_n`, for the VIA and interrupt-acknowledge cycles;
- `berr`, on timeout.

Also owns the boot-time ROM overlay flag and produces E-synchronous VIA strobes.

---
 rtl/mac_bus_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mac_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_bus_ctrl.sv
// Address decoder and bus-cycle terminator for a 68000-style CPU bus: chip selects,
// dtack_n/vpa_n/berr termination, boot ROM overlay and E-synchronous VIA strobes.
module mac_bus_ctrl #(
    parameter int RAM_WS  = 1,
    parameter int ROM_WS  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        phi1,
    input  logic        phi2,
    input  logic [23:0] addr,
    input  logic        as_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic        rw_n,
    input  logic [2:0]  fc,
    input  logic        vma_n,
    input  logic        e_negclken,
    input  logic        dev_ready,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr,
    output logic        ram_cs,
    output logic        rom_cs,
    output logic        scsi_cs,
    output logic        scc_cs,
    output logic        iwm_cs,
    output logic        via_cs,
    output logic        via_rd,
    output logic        via_wr,
    output logic        overlay
);
    // state | meaning
    // IDLE  | no cycle, waiting for as_n low
    // LATCH | decode/rw_n captured, chip select being raised
    // WAIT  | counting wait states / timeout, waiting for termination
    // TERM  | response held until as_n returns high
    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_WAIT, S_TERM} state_t;
    typedef enum logic [2:0] {RG_IACK, RG_RAM, RG_ROM, RG_SCSI, RG_SCC, RG_IWM, RG_VIA, RG_NONE} region_t;

    localparam logic [7:0] RAM_LAST = 8'(RAM_WS - 1);
    localparam logic [7:0] ROM_LAST = 8'(ROM_WS - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t     r_state, w_state_nxt;
    region_t    r_region, w_region;
    logic       r_rw_n, r_rom_hi, w_rom_hi, r_overlay, r_via_done;
    logic [7:0] r_wait_cnt, r_to_cnt;
    logic       r_dtack_n, r_vpa_n, r_berr, r_via_rd, r_via_wr;
    logic [5:0] r_cs, w_cs_nxt;
    logic       w_dtack_n_nxt, w_vpa_n_nxt, w_berr_nxt, w_via_rd_nxt, w_via_wr_nxt;
    logic       w_dtack_hit, w_vpa_hit, w_to_hit, w_strobe;
    logic       w_unused;

    // Data strobes, phi1 and the low address bits play no part in region selection.
    assign w_unused = ^{phi1, uds_n, lds_n, addr[18:0]};

    always_comb begin
        w_region = RG_NONE;
        if (fc == 3'b111)                 w_region = RG_IACK;
        else if (addr[23:22] == 2'b00)    w_region = r_overlay ? RG_ROM : RG_RAM;
        else if (addr[23:20] == 4'h4)     w_region = RG_ROM;
        else if (addr[23:19] == 5'b01011) w_region = RG_SCSI;
        else if (addr[23:22] == 2'b10)    w_region = RG_SCC;
        else if (addr[23:21] == 3'b110)   w_region = RG_IWM;
        else if (addr[23:19] == 5'b11101) w_region = RG_VIA;
    end
    assign w_rom_hi = (fc != 3'b111) && (addr[23:20] == 4'h4);

    always_comb begin
        w_dtack_hit = 1'b0;
        case (r_region)
            RG_RAM:          w_dtack_hit = phi2 && (r_wait_cnt == RAM_LAST);
            RG_ROM:          w_dtack_hit = phi2 && (r_wait_cnt == ROM_LAST);
            RG_SCSI, RG_IWM: w_dtack_hit = phi2 && dev_ready;
            RG_SCC:          w_dtack_hit = phi2;
            default:         w_dtack_hit = 1'b0;
        endcase
    end
    assign w_vpa_hit = (r_region == RG_VIA) || (r_region == RG_IACK);
    assign w_to_hit  = phi2 && (r_to_cnt == TO_LAST);
    assign w_strobe  = (r_state == S_TERM) && !as_n && (r_region == RG_VIA) && !vma_n
                       && e_negclken && !r_via_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!as_n) w_state_nxt = S_LATCH;
            S_LATCH: w_state_nxt = as_n ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (as_n)                                     w_state_nxt = S_IDLE;
                else if (w_vpa_hit || w_dtack_hit || w_to_hit) w_state_nxt = S_TERM;
            end
            S_TERM:  if (as_n) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; a dtack condition beats the timeout.
    always_comb begin
        w_dtack_n_nxt = r_dtack_n;
        w_vpa_n_nxt   = r_vpa_n;
        w_berr_nxt    = r_berr;
        w_cs_nxt      = r_cs;
        w_via_rd_nxt  = 1'b0;
        w_via_wr_nxt  = 1'b0;
        if ((r_state != S_IDLE) && as_n) begin
            w_dtack_n_nxt = 1'b1;
            w_vpa_n_nxt   = 1'b1;
            w_berr_nxt    = 1'b0;
            w_cs_nxt      = 6'b0;
        end else begin
            case (r_state)
                S_LATCH: begin
                    case (r_region)
                        RG_RAM:  w_cs_nxt = 6'b000001;
                        RG_ROM:  w_cs_nxt = 6'b000010;
                        RG_SCSI: w_cs_nxt = 6'b000100;
                        RG_SCC:  w_cs_nxt = 6'b001000;
                        RG_IWM:  w_cs_nxt = 6'b010000;
                        RG_VIA:  w_cs_nxt = 6'b100000;
                        default: w_cs_nxt = 6'b000000;
                    endcase
                end
                S_WAIT: begin
                    if (w_vpa_hit)        w_vpa_n_nxt   = 1'b0;
                    else if (w_dtack_hit) w_dtack_n_nxt = 1'b0;
                    else if (w_to_hit)    w_berr_nxt    = 1'b1;
                end
                S_TERM: begin
                    w_via_rd_nxt = w_strobe && r_rw_n;
                    w_via_wr_nxt = w_strobe && !r_rw_n;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dtack_n <= 1'b1;
            r_vpa_n   <= 1'b1;
            r_berr    <= 1'b0;
            r_cs      <= 6'b0;
            r_via_rd  <= 1'b0;
            r_via_wr  <= 1'b0;
        end else begin
            r_dtack_n <= w_dtack_n_nxt;
            r_vpa_n   <= w_vpa_n_nxt;
            r_berr    <= w_berr_nxt;
            r_cs      <= w_cs_nxt;
            r_via_rd  <= w_via_rd_nxt;
            r_via_wr  <= w_via_wr_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_region   <= RG_NONE;
            r_rw_n     <= 1'b1;
            r_rom_hi   <= 1'b0;
            r_overlay  <= 1'b1;
            r_via_done <= 1'b0;
            r_wait_cnt <= 8'd0;
            r_to_cnt   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: if (!as_n) begin
                    r_region <= w_region;
                    r_rw_n   <= rw_n;
                    r_rom_hi <= w_rom_hi;
                end
                S_LATCH: begin
                    r_wait_cnt <= 8'd0;
                    r_to_cnt   <= 8'd0;
                    r_via_done <= 1'b0;
                    if (r_rom_hi) r_overlay <= 1'b0;
                end
                S_WAIT: if (phi2) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                    r_to_cnt   <= r_to_cnt + 8'd1;
                end
                S_TERM: if (w_strobe) r_via_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign dtack_n = r_dtack_n;
    assign vpa_n   = r_vpa_n;
    assign berr    = r_berr;
    assign ram_cs  = r_cs[0];
    assign rom_cs  = r_cs[1];
    assign scsi_cs = r_cs[2];
    assign scc_cs  = r_cs[3];
    assign iwm_cs  = r_cs[4];
    assign via_cs  = r_cs[5];
    assign via_rd  = r_via_rd;
    assign via_wr  = r_via_wr;
    assign overlay = r_overlay;
endmodule

// File: tb/tb_mac_bus_ctrl.sv
// Bench for mac_bus_ctrl: cycle-level behavioural model checked every clk, plus
// directed bus cycles with hand-computed literal expectations.
module tb_mac_bus_ctrl;
    localparam int RAM_WS = 1, ROM_WS = 2, TIMEOUT = 64;
    localparam int M_IACK = 0, M_RAM = 1, M_ROM = 2, M_SCSI = 3, M_SCC = 4, M_IWM = 5,
                   M_VIA = 6, M_NONE = 7;

    logic clk, reset_n, phi1, phi2, as_n, uds_n, lds_n, rw_n, vma_n, e_negclken, dev_ready;
    logic [23:0] addr;
    logic [2:0]  fc;
    logic dtack_n, vpa_n, berr, ram_cs, rom_cs, scsi_cs, scc_cs, iwm_cs, via_cs;
    logic via_rd, via_wr, overlay;

    int checks = 0, errors = 0, pcnt = 0;
    bit started = 0;

    mac_bus_ctrl #(.RAM_WS(RAM_WS), .ROM_WS(ROM_WS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .phi1(phi1), .phi2(phi2), .addr(addr), .as_n(as_n),
        .uds_n(uds_n), .lds_n(lds_n), .rw_n(rw_n), .fc(fc), .vma_n(vma_n),
        .e_negclken(e_negclken), .dev_ready(dev_ready), .dtack_n(dtack_n), .vpa_n(vpa_n),
        .berr(berr), .ram_cs(ram_cs), .rom_cs(rom_cs), .scsi_cs(scsi_cs), .scc_cs(scc_cs),
        .iwm_cs(iwm_cs), .via_cs(via_cs), .via_rd(via_rd), .via_wr(via_wr), .overlay(overlay)
    );

    logic [5:0]  dut_cs;
    logic [11:0] dut_vec;
    assign dut_cs  = {via_cs, iwm_cs, scc_cs, scsi_cs, rom_cs, ram_cs};
    assign dut_vec = {dtack_n, vpa_n, berr, dut_cs, via_rd, via_wr, overlay};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // phi1/phi2 every 4 clk, E falling edge every 10 clk.
    initial begin
        phi1 = 0; phi2 = 0; e_negclken = 0;
        forever begin
            @(negedge clk);
            pcnt++;
            phi1 = (pcnt % 4 == 0);
            phi2 = (pcnt % 4 == 2);
            e_negclken = (pcnt % 10 == 7);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_decode(input logic [23:0] a, input logic [2:0] f, input logic ovl);
        if (f == 3'b111) return M_IACK;
        if (a <= 24'h3FFFFF) return ovl ? M_ROM : M_RAM;
        if (a >= 24'h400000 && a <= 24'h4FFFFF) return M_ROM;
        if (a >= 24'h580000 && a <= 24'h5FFFFF) return M_SCSI;
        if (a >= 24'h800000 && a <= 24'hBFFFFF) return M_SCC;
        if (a >= 24'hC00000 && a <= 24'hDFFFFF) return M_IWM;
        if (a >= 24'hE80000 && a <= 24'hEFFFFF) return M_VIA;
        return M_NONE;
    endfunction

    function automatic logic [5:0] m_cs_of(input int rg);
        case (rg)
            M_RAM:  return 6'b000001;
            M_ROM:  return 6'b000010;
            M_SCSI: return 6'b000100;
            M_SCC:  return 6'b001000;
            M_IWM:  return 6'b010000;
            M_VIA:  return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    logic m_dtack_n, m_vpa_n, m_berr, m_rd, m_wr, m_overlay, m_rw;
    logic [5:0] m_cs;
    int  m_k, m_region, m_nphi;
    bit  m_active, m_done, m_strobed, m_rom_hi, m_dtack_ok;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_dtack_n = 1; m_vpa_n = 1; m_berr = 0; m_cs = 0; m_rd = 0; m_wr = 0;
            m_overlay = 1; m_active = 0;
        end else begin
            m_rd = 0; m_wr = 0;
            if (as_n) begin
                m_dtack_n = 1; m_vpa_n = 1; m_berr = 0; m_cs = 0; m_active = 0;
            end else if (!m_active) begin
                m_active = 1; m_k = 0; m_nphi = 0; m_done = 0; m_strobed = 0;
                m_region = m_decode(addr, fc, m_overlay);
                m_rw = rw_n;
                m_rom_hi = (fc != 3'b111) && (addr >= 24'h400000) && (addr <= 24'h4FFFFF);
            end else begin
                m_k++;
                if (m_k == 1) begin
                    m_cs = m_cs_of(m_region);
                    if (m_rom_hi) m_overlay = 0;
                end else if (!m_done) begin
                    if (phi2) m_nphi++;
                    case (m_region)
                        M_RAM:         m_dtack_ok = (m_nphi == RAM_WS);
                        M_ROM:         m_dtack_ok = (m_nphi == ROM_WS);
                        M_SCSI, M_IWM: m_dtack_ok = dev_ready;
                        M_SCC:         m_dtack_ok = 1;
                        default:       m_dtack_ok = 0;
                    endcase
                    if (m_region == M_VIA || m_region == M_IACK) begin
                        m_vpa_n = 0; m_done = 1;
                    end else if (phi2 && m_dtack_ok) begin
                        m_dtack_n = 0; m_done = 1;
                    end else if (phi2 && m_nphi == TIMEOUT) begin
                        m_berr = 1; m_done = 1;
                    end
                end else if (m_region == M_VIA && !vma_n && e_negclken && !m_strobed) begin
                    m_strobed = 1;
                    m_rd = m_rw;
                    m_wr = !m_rw;
                end
            end
        end
    end

    always @(negedge clk)
        if (started)
            check("outputs", {20'b0, dut_vec},
                  {20'b0, m_dtack_n, m_vpa_n, m_berr, m_cs, m_rd, m_wr, m_overlay});

    // ---------------- directed cycles ----------------
    // kind: 1 dtack, 2 vpa, 3 berr, 9 more than one at once
    task automatic bus_cycle(input logic [23:0] a, input logic [2:0] f, input logic rw,
                             input logic vma, input int ready_after, input int hold,
                             output int kind, output int resp_phi, output logic [5:0] cs_seen,
                             output int rd_cnt, output int wr_cnt,
                             output logic dtack_seen, output logic berr_seen);
        int e, nphi, after, n;
        e = 0; nphi = 0; after = 0;
        kind = 0; resp_phi = -1; cs_seen = 0; rd_cnt = 0; wr_cnt = 0;
        dtack_seen = 0; berr_seen = 0;
        @(negedge clk);
        addr = a; fc = f; rw_n = rw; vma_n = vma; as_n = 0; uds_n = 0; lds_n = 0;
        while (1) begin
            @(posedge clk);
            if (e >= 2 && phi2) nphi++;
            #1;
            cs_seen |= dut_cs;
            if (!dtack_n) dtack_seen = 1;
            if (berr) berr_seen = 1;
            if (via_rd) rd_cnt++;
            if (via_wr) wr_cnt++;
            if (kind == 0) begin
                n = int'(!dtack_n) + int'(!vpa_n) + int'(berr);
                if (n > 1)         kind = 9;
                else if (!dtack_n) kind = 1;
                else if (!vpa_n)   kind = 2;
                else if (berr)     kind = 3;
                if (kind != 0) resp_phi = nphi;
                else if (ready_after >= 0 && nphi >= ready_after) dev_ready = 1;
            end else begin
                after++;
                if (after >= hold) break;
            end
            e++;
            if (e > 400) begin
                checks++; errors++;
                $display("FAIL cycle_bound: no termination within 400 clk for addr 0x%0h", a);
                break;
            end
        end
        @(negedge clk);
        as_n = 1; uds_n = 1; lds_n = 1; dev_ready = 0;
        @(posedge clk); #1;
        check("release", {23'b0, dtack_n, vpa_n, berr, dut_cs}, {23'b0, 3'b110, 6'b0});
        @(negedge clk);
    endtask

    initial begin
        int kind, rphi, rd, wr, w;
        logic [5:0] cs;
        logic dseen, bseen;
        reset_n = 0; as_n = 1; uds_n = 1; lds_n = 1; rw_n = 1; vma_n = 1; dev_ready = 0;
        addr = 0; fc = 3'b110;
        repeat (3) @(negedge clk);
        check("reset_vec", {20'b0, dut_vec}, {20'b0, 12'b110_000000_00_1});
        reset_n = 1;
        started = 1;
        repeat (2) @(negedge clk);

        // overlay set: low memory is ROM with two wait states
        bus_cycle(24'h000100, 3'b110, 1, 1, -1, 3, kind, rphi, cs, rd, wr, dseen, bseen);
        check("rom0_kind", kind, 1); check("rom0_phi", rphi, 2);
        check("rom0_cs", cs, 6'b000010); check("rom0_overlay", overlay, 1);

        bus_cycle(24'h400000, 3'b110, 1, 1, -1, 3, kind, rphi, cs, rd, wr, dseen, bseen);
        check("romhi_kind", kind, 1); check("romhi_phi", rphi, 2);
        check("romhi_overlay", overlay, 0);

        bus_cycle(24'h000100, 3'b110, 1, 1, -1, 3, kind, rphi, cs, rd, wr, dseen, bseen);
        check("ram_kind", kind, 1); check("ram_phi", rphi, 1); check("ram_cs", cs, 6'b000001);

        bus_cycle(24'h580010, 3'b101, 0, 1, 0, 3, kind, rphi, cs, rd, wr, dseen, bseen);
        check("scsi_kind", kind, 1); check("scsi_phi", rphi, 1); check("scsi_cs", cs, 6'b000100);

        bus_cycle(24'hEFE1FE, 3'b101, 0, 0, -1, 25, kind, rphi, cs, rd, wr, dseen, bseen);
        check("viaw_kind", kind, 2); check("viaw_dtack", dseen, 0);
        check("viaw_wr", wr, 1); check("viaw_rd", rd, 0); check("viaw_cs", cs, 6'b100000);

        bus_cycle(24'hEFE1FE, 3'b101, 1, 0, -1, 25, kind, rphi, cs, rd, wr, dseen, bseen);
        check("viar_rd", rd, 1); check("viar_wr", wr, 0);

        bus_cycle(24'hEFE1FE, 3'b101, 1, 1, -1, 25, kind, rphi, cs, rd, wr, dseen, bseen);
        check("via_novma_kind", kind, 2); check("via_novma_rd", rd, 0);

        bus_cycle(24'hFFFFF5, 3'b111, 1, 1, -1, 3, kind, rphi, cs, rd, wr, dseen, bseen);
        check("iack_kind", kind, 2); check("iack_cs", cs, 6'b0); check("iack_berr", bseen, 0);

        bus_cycle(24'h600000, 3'b101, 1, 1, -1, 5, kind, rphi, cs, rd, wr, dseen, bseen);
        check("unmap_kind", kind, 3); check("unmap_phi", rphi, 64);
        check("unmap_cs", cs, 6'b0); check("unmap_dtack", dseen, 0);

        bus_cycle(24'hC00000, 3'b101, 1, 1, 10, 3, kind, rphi, cs, rd, wr, dseen, bseen);
        check("iwm_kind", kind, 1); check("iwm_phi", rphi, 11);
        check("iwm_berr", bseen, 0); check("iwm_cs", cs, 6'b010000);

        // reset pulsed while a RAM cycle sits in WAIT
        @(negedge clk);
        addr = 24'h000100; fc = 3'b101; rw_n = 1; as_n = 0;
        w = 0;
        while (!ram_cs && w < 10) begin
            @(posedge clk); #1; w++;
        end
        check("rst_ramcs_seen", ram_cs, 1);
        #1 reset_n = 0;
        #1;
        check("rst_dtack", dtack_n, 1); check("rst_ramcs", ram_cs, 0);
        check("rst_overlay", overlay, 1);
        @(negedge clk); as_n = 1;
        @(negedge clk); reset_n = 1;
        repeat (2) @(negedge clk);

        bus_cycle(24'h000100, 3'b110, 1, 1, -1, 3, kind, rphi, cs, rd, wr, dseen, bseen);
        check("post_rst_kind", kind, 1); check("post_rst_phi", rphi, 2);
        check("post_rst_cs", cs, 6'b000010);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
